// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Radix-2 iterative multiply/divide unit that sits beside the ALU in EX and
// owns the architectural HI/LO registers. One partial-product (multiply) or
// one quotient bit (restoring divide) is produced per clock. MULT/MULTU/DIV/
// DIVU take WIDTH clocks after acceptance; MTHI/MTLO write HI/LO in one cycle.
//
// Handshake: a request is taken on a rising edge where start=1, flush=0 and
// the unit is idle (busy=0, which includes the cycle done=1). A start seen
// while busy=1 is dropped, not queued. flush beats start and aborts a running
// operation without touching HI/LO. done pulses for one cycle, coincident
// with the HI/LO update of an iterative operation.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-low reset (dominates all inputs)
//   a      in   WIDTH  rs operand: dividend / multiplicand / MTHI-MTLO data
//   b      in   WIDTH  rt operand: divisor / multiplier
//   op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 nop
//   start  in   request from EX, sampled only while idle
//   flush  in   squash from branch/exception logic
//   busy   out  iterative operation in progress (hazard-unit stall)
//   done   out  one-cycle pulse when MULT/DIV results land in HI/LO
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W = WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Multiply: {partial high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*W-1:0]   acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [W-1:0]     opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             done_q, done_d;

    // ---------------- one iteration of each datapath ----------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     rem_sh;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_next;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right, keeping
    // the carry as the new top bit.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the trial difference when it does not borrow. The difference is
    // below 2^W whenever it is kept, so a W-bit subtract is sufficient.
    // A zero divisor yields an all-ones quotient and leaves the dividend
    // magnitude in the remainder, which is exactly the divide-by-zero result.
    assign rem_sh   = acc_q[2*W-1:W-1];
    assign div_ge   = (rem_sh >= {1'b0, opnd_q});
    assign div_diff = rem_sh[W-1:0] - opnd_q;
    assign div_next = {(div_ge ? div_diff : rem_sh[W-1:0]), acc_q[W-2:0], div_ge};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // ---------------- next state / datapath control ----------------
    logic           signed_op;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        // MULT and DIV are the even codes of the iterative group.
        signed_op = ~op[0];
        a_mag     = (signed_op && a[W-1]) ? -a : a;
        b_mag     = (signed_op && b[W-1]) ? -b : b;

        prod_fix  = neg_res_q ? -mul_next : mul_next;
        quo_fix   = neg_res_q ? -div_next[W-1:0] : div_next[W-1:0];
        rem_fix   = neg_rem_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = op[1];
                            opnd_d    = op[1] ? b_mag : a_mag;
                            acc_d     = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                            // Divide by zero keeps the all-ones quotient as is.
                            neg_res_d = signed_op && (a[W-1] ^ b[W-1]) &&
                                        !(op[1] && (b == '0));
                            neg_rem_d = signed_op && a[W-1];
                            cnt_d     = '0;
                            state_d   = S_CALC;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            {hi_d, lo_d} = prod_fix;
                        end
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_CALC);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Scenario tasks run in sequence from one initial block. Expected HI/LO come
// from plain 64-bit integer arithmetic on the operands (signed / unsigned
// multiply, truncating divide, divide-by-zero convention), not from any
// bit-serial recurrence.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        start;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: returns {hi, lo} ----------------
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        logic [63:0] ux = {32'd0, x};
        logic [63:0] uy = {32'd0, y};
        longint      q;
        longint      r;
        logic [63:0] res;
        res = '0;
        case (o)
            3'd0: res = sx * sy;
            3'd1: res = ux * uy;
            3'd2: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {(x % y), (x / y)};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; operands are scrambled afterwards so a unit that
    // fails to capture them at acceptance gets the wrong answer.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts busy cycles until done is seen; returns at the sample where
    // done=1 (so a new request can be driven in that same cycle).
    task automatic wait_done(output int busy_cycles, output bit got_done, output bit busy_at_done);
        busy_cycles  = 0;
        got_done     = 1'b0;
        busy_at_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done     = 1'b1;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cycles++;
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (hi !== 32'd0)  begin n_err++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        n_cmp++; if (lo !== 32'd0)  begin n_err++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [7] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2};
        logic [31:0] t_a  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'h0000_0007, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] t_b  [7] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002,
                                  32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] t_hi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                                  32'h0000_0001, 32'h0000_0000, 32'h1234_5678};
        logic [31:0] t_lo [7] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFD,
                                  32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};
        int bc;
        bit gd;
        bit bd;
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(bc, gd, bd);
            n_cmp++; if (!gd)        begin n_err++; $display("FAIL dir%0d_done got=0 exp=1", i); end
            n_cmp++; if (bc != 32)   begin n_err++; $display("FAIL dir%0d_busy_cycles got=%0d exp=32", i, bc); end
            n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bd); end
            n_cmp++; if (hi !== t_hi[i]) begin n_err++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, t_hi[i]); end
            n_cmp++; if (lo !== t_lo[i]) begin n_err++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, t_lo[i]); end
            tick();
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        int bc;
        bit gd;
        bit bd;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: x = 32'h8000_0000;
                default: ;
            endcase
            exp = model(o, x, y);
            issue(o, x, y);
            wait_done(bc, gd, bd);
            n_cmp++; if (!gd || bc != 32) begin n_err++; $display("FAIL rnd%0d_timing done=%b cycles=%0d exp done=1 cycles=32", i, gd, bc); end
            n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, x, y, hi, lo, exp[63:32], exp[31:0]); end
            tick();
        end
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        issue(3'd4, h, 32'd0);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi_status busy=%b done=%b exp 0 0", busy, done); end
        n_cmp++; if (hi !== h) begin n_err++; $display("FAIL mthi_hi got=%h exp=%h", hi, h); end
        issue(3'd5, l, 32'd0);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mtlo_status busy=%b done=%b exp 0 0", busy, done); end
        n_cmp++; if (lo !== l) begin n_err++; $display("FAIL mtlo_lo got=%h exp=%h", lo, l); end
    endtask

    task automatic test_mthi_mtlo();
        preload(32'hAAAA_AAAA, 32'h5555_5555);
        // op 6/7 is a no-op.
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        n_cmp++; if ({hi, lo, busy} !== {32'hAAAA_AAAA, 32'h5555_5555, 1'b0}) begin
            n_err++; $display("FAIL nop_op hi=%h lo=%h busy=%b exp AAAAAAAA 55555555 0", hi, lo, busy);
        end
    endtask

    task automatic test_flush();
        int seen_done;
        preload(32'hAAAA_AAAA, 32'h5555_5555);
        issue(3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            tick();
        end
        n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL flush_no_done got=%0d exp=0", seen_done); end
        n_cmp++; if ({hi, lo} !== {32'hAAAA_AAAA, 32'h5555_5555}) begin
            n_err++; $display("FAIL flush_hilo got=%h_%h exp=AAAAAAAA_55555555", hi, lo);
        end
    endtask

    task automatic test_ignore_start();
        int bc;
        bit gd;
        bit bd;
        preload(32'hAAAA_AAAA, 32'h5555_5555);
        issue(3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) tick();
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        n_cmp++; if (hi !== 32'hAAAA_AAAA || busy !== 1'b1) begin
            n_err++; $display("FAIL busy_start_ignored hi=%h busy=%b exp AAAAAAAA 1", hi, busy);
        end
        wait_done(bc, gd, bd);
        n_cmp++; if (!gd || bc != 27) begin n_err++; $display("FAIL ignore_timing done=%b cycles=%0d exp done=1 cycles=27", gd, bc); end
        n_cmp++; if ({hi, lo} !== 64'd12) begin n_err++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000000c", hi, lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        preload(32'hAAAA_AAAA, 32'h5555_5555);
        issue(3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if ({hi, lo, busy, done} !== 66'd0) begin
            n_err++; $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b exp all 0", hi, lo, busy, done);
        end
        for (int i = 0; i < 35; i++) tick();
        n_cmp++; if ({hi, lo, busy} !== 65'd0) begin
            n_err++; $display("FAIL reset_mid_after hi=%h lo=%h busy=%b exp all 0", hi, lo, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] e1, e2;
        int bc;
        bit gd;
        bit bd;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = 32'($urandom_range(1, 32'hFFFF));
        e1 = model(3'd1, x1, y1);
        e2 = model(3'd3, x2, y2);
        issue(3'd1, x1, y1);
        wait_done(bc, gd, bd);
        n_cmp++; if (!gd || {hi, lo} !== e1) begin n_err++; $display("FAIL b2b_first done=%b got=%h_%h exp=%h_%h", gd, hi, lo, e1[63:32], e1[31:0]); end
        issue(3'd3, x2, y2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        wait_done(bc, gd, bd);
        n_cmp++; if (!gd || bc != 32) begin n_err++; $display("FAIL b2b_timing done=%b cycles=%0d exp done=1 cycles=32", gd, bc); end
        n_cmp++; if ({hi, lo} !== e2) begin n_err++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", hi, lo, e2[63:32], e2[31:0]); end
        tick();
        // start together with flush while idle: nothing is accepted.
        flush = 1'b1;
        issue(3'd0, 32'd5, 32'd6);
        issue(3'd4, 32'h0BAD_F00D, 32'd0);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || hi !== e2[63:32]) begin
            n_err++; $display("FAIL start_flush_idle busy=%b hi=%h exp busy=0 hi=%h", busy, hi, e2[63:32]);
        end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL start_flush_idle_later busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst   = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        start = 1'b0;
        flush = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_mthi_mtlo();
        test_flush();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
